engine2vga_writer: RTL



---
 rtl/engine2vga_writer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/engine2vga_writer.sv
`default_nettype none
// ============================================================================
// Module   : engine2vga_writer
// Function : Collects Mandelbrot engine results through a small FIFO, maps
//            each (x, y, iter) to a frame-buffer address and colour index,
//            and drives the VGA frame-buffer write port. Also provides a
//            hardware clear-screen sweep and end-of-frame pulse.
// Revision : 1.0 - initial release
// ============================================================================
module engine2vga_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ITER_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_iCLK,
  input  logic              iRST,
  input  logic              iPix_valid,
  output logic              oPix_ready,
  input  logic [9:0]        iPix_x,
  input  logic [8:0]        iPix_y,
  input  logic [ITER_W-1:0] iPix_iter,
  input  logic [ITER_W-1:0] iMax_iter,
  input  logic              iClear,
  output logic [7:0]        writedata_oDATA,
  output logic [18:0]       address_oADDR,
  output logic              write_oWR_en,
  output logic              oBusy,
  output logic              oFrame_done,
  output logic [15:0]       oDrop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 10 + 9 + ITER_W;

  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0]    C_H_RES    = 10'(H_RES);
  localparam logic [8:0]    C_V_RES    = 9'(V_RES);
  localparam logic [18:0]   C_LAST_PIX = 19'(H_RES * V_RES - 1);
  localparam logic [15:0]   C_DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t         r_state;

  // Input FIFO storage and bookkeeping
  logic [DW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Output stage and control registers
  logic           r_wr_en;
  logic [18:0]    r_addr;
  logic [7:0]     r_data;
  logic           r_frame_done;
  logic [15:0]    r_drop_cnt;
  logic [18:0]    r_pix_cnt;
  logic [18:0]    r_clr_addr;
  logic           r_clr_last;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [DW-1:0]  w_head;
  logic [9:0]     w_x;
  logic [8:0]     w_y;
  logic [ITER_W-1:0] w_iter;
  logic           w_in_range;
  logic [18:0]    w_addr;
  logic [7:0]     w_index;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Ready only from registered state; the final clear strobe cycle still
  // counts as part of the sweep, so acceptance resumes one cycle later.
  assign oPix_ready = (r_state == ST_RUN) && !w_full && !r_clr_last;

  assign w_push = iPix_valid && oPix_ready;
  assign w_pop  = (r_state != ST_CLEAR) && !w_empty;

  assign w_head = r_mem[r_rd_ptr];
  assign w_x    = w_head[DW-1 -: 10];
  assign w_y    = w_head[DW-11 -: 9];
  assign w_iter = w_head[ITER_W-1:0];

  assign w_in_range = (w_x < C_H_RES) && (w_y < C_V_RES);

  // Row stride of 640 as y*512 + y*128 + x, all at 19 bits
  assign w_addr = {1'b0, w_y, 9'b0} + {3'b0, w_y, 7'b0} + {9'b0, w_x};

  // Colour index 0 is reserved for points inside the set
  always_comb begin
    w_index = 8'h00;
    if (w_iter >= iMax_iter)
      w_index = 8'h00;
    else if (w_iter[7:0] == 8'h00)
      w_index = 8'h01;
    else
      w_index = w_iter[7:0];
  end

  // FIFO storage write; contents need no reset because pointers qualify them
  always_ff @(posedge clk_iCLK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {iPix_x, iPix_y, iPix_iter};
  end

  // FIFO pointer and occupancy tracking
  always_ff @(posedge clk_iCLK or posedge iRST) begin
    if (iRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control FSM with registered write port, frame counter and drop counter
  always_ff @(posedge clk_iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= ST_RUN;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_clr_addr   <= '0;
      r_clr_last   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_clr_last   <= 1'b0;

      case (r_state)
        ST_RUN: begin
          if (iClear)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Wait until nothing is queued and the last pixel strobe is out
          if (w_empty && !r_wr_en) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          r_wr_en <= 1'b1;
          r_addr  <= r_clr_addr;
          r_data  <= 8'h00;
          if (r_clr_addr == C_LAST_PIX) begin
            r_state    <= ST_RUN;
            r_clr_addr <= '0;
            r_pix_cnt  <= '0;
            r_drop_cnt <= '0;
            r_clr_last <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      // Pop path is active in RUN and DRAIN only
      if (w_pop) begin
        if (w_in_range) begin
          r_wr_en <= 1'b1;
          r_addr  <= w_addr;
          r_data  <= w_index;
          if (r_pix_cnt == C_LAST_PIX) begin
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
        end else if (r_drop_cnt != C_DROP_MAX) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  assign write_oWR_en    = r_wr_en;
  assign address_oADDR   = r_addr;
  assign writedata_oDATA = r_data;
  assign oFrame_done     = r_frame_done;
  assign oDrop_cnt       = r_drop_cnt;
  assign oBusy           = (r_state != ST_RUN) || r_clr_last;

endmodule
`default_nettype wire
